// File: rtl/ldpc_pkg.sv
// Shared defaults, state encoding and constant helpers for the streaming LDPC encoder.
// The defaults reproduce the (11,6) code of the earlier fixed combinational encoder.
package ldpc_pkg;
   localparam int DEF_N = 11;
   localparam int DEF_K = 6;
   localparam logic [29:0] DEF_P_MATRIX = 30'h3F119998;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Counter width for v states; never narrower than one bit.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/ldpc_parity_slice.sv
// GF(2) parity contribution of one W-bit slice of the info word.
// Lanes whose mask bit is clear contribute nothing.
module ldpc_parity_slice
   import ldpc_pkg::*;
#(
   parameter int M = 5,
   parameter int W = 2
) (
   input  logic [W-1:0]   info,
   input  logic [W*M-1:0] rows,
   input  logic [W-1:0]   lane_mask,
   output logic [M-1:0]   parity
);

   always_comb begin
      parity = '0;
      for (int j = 0; j < W; j++) begin
         if (info[j] && lane_mask[j]) parity = parity ^ rows[j*M +: M];
      end
   end

endmodule

// File: rtl/ldpc_stream_encoder.sv
// Systematic LDPC encoder: accepts a K-bit word, accumulates parity W bits per cycle,
// then holds {info, parity} until the downstream stage takes it.
module ldpc_stream_encoder
   import ldpc_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int K = DEF_K,
   parameter int W = 2,
   parameter logic [K*(N-K)-1:0] P_MATRIX = DEF_P_MATRIX,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [K-1:0]     info_bits,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [N-1:0]     codeword,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_count
);

   localparam int M  = N - K;
   localparam int C  = ceil_div(K, W);
   localparam int SW = clog2_min1(C);
   localparam int PW = C * W;
   localparam logic [SW-1:0] LAST = SW'(C - 1);

   state_t            state, state_nxt;
   logic [SW-1:0]     slice;
   logic [M-1:0]      acc;
   logic [M-1:0]      contrib;
   logic [K-1:0]      info_q;
   logic [N-1:0]      codeword_q;
   logic [CNT_W-1:0]  count;
   logic [PW-1:0]     info_pad;
   logic [PW*M-1:0]   rows_pad;
   logic [W-1:0]      lane_info;
   logic [W-1:0]      lane_mask;
   logic [W*M-1:0]    lane_rows;
   logic              accept, handoff, last_step;

   assign o_ready   = (state == IDLE) && i_en;
   assign accept    = i_valid && o_ready;
   assign handoff   = (state == HOLD) && i_ready && i_en;
   assign last_step = (state == CALC) && i_en && (slice == LAST);

   assign o_valid  = (state == HOLD);
   assign o_busy   = (state != IDLE);
   assign codeword = codeword_q;
   assign o_count  = count;

   // Zero-pad to a whole number of slices so the final slice never reads past K.
   assign info_pad = PW'(info_q);
   assign rows_pad = (PW*M)'(P_MATRIX);

   always_comb begin
      lane_mask = '0;
      lane_info = info_pad[slice*W +: W];
      lane_rows = rows_pad[slice*W*M +: W*M];
      for (int j = 0; j < W; j++) begin
         lane_mask[j] = ((int'(slice) * W + j) < K);
      end
   end

   ldpc_parity_slice #(
      .M (M),
      .W (W)
   ) u_slice (
      .info      (lane_info),
      .rows      (lane_rows),
      .lane_mask (lane_mask),
      .parity    (contrib)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = CALC;
         CALC:    if (last_step) state_nxt = HOLD;
         HOLD:    if (handoff)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slice      <= '0;
         acc        <= '0;
         codeword_q <= '0;
         count      <= '0;
      end else begin
         if (accept) begin
            slice <= '0;
            acc   <= '0;
         end
         if ((state == CALC) && i_en) begin
            acc <= acc ^ contrib;
            if (last_step) codeword_q <= {info_q, acc ^ contrib};
            else           slice      <= slice + SW'(1);
         end
         if (handoff) count <= count + CNT_W'(1);
      end
   end

   // Info register is pure data: only the accept strobe matters.
   always_ff @(posedge clk) begin
      if (accept) info_q <= info_bits;
   end

endmodule

// File: tb/tb_ldpc_stream_encoder.sv
// Bench for ldpc_stream_encoder: three instances (W=2, W=4 with 2-bit counter, W=1)
// share stimulus; a scoreboard per instance checks against a whole-word parity model.
module tb_ldpc_stream_encoder;

   localparam logic [29:0] P = 30'h3F119998;

   logic        clk = 1'b0;
   logic        rst_n, i_en, i_valid, i_ready;
   logic [5:0]  info_bits;
   logic        rdy_v[3];
   logic        vld_v[3];
   logic        busy_v[3];
   logic [10:0] cw_v[3];
   logic [15:0] cnt_v[3];
   logic [15:0] cnt0, cnt2;
   logic [1:0]  cnt1;

   int          cc[3]      = '{3, 2, 6};
   logic [15:0] cmask[3]   = '{16'hFFFF, 16'h0003, 16'hFFFF};

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          b2b = 1'b0;

   logic [10:0] exp_q[3][$];
   logic [10:0] hist0[$];
   int          acc_cnt[3];
   int          acc_cyc[3];
   int          rise_cyc[3];
   int          prev_acc[3];
   int          en_edges[3];
   bit          busy_m[3];
   bit          wait_m[3];
   logic [15:0] cnt_m[3];
   logic [10:0] last_cw[3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ldpc_stream_encoder #(.W(2), .CNT_W(16)) u_w2 (
      .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_valid(i_valid), .o_ready(rdy_v[0]),
      .info_bits(info_bits), .o_valid(vld_v[0]), .i_ready(i_ready), .codeword(cw_v[0]),
      .o_busy(busy_v[0]), .o_count(cnt0));
   ldpc_stream_encoder #(.W(4), .CNT_W(2)) u_w4 (
      .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_valid(i_valid), .o_ready(rdy_v[1]),
      .info_bits(info_bits), .o_valid(vld_v[1]), .i_ready(i_ready), .codeword(cw_v[1]),
      .o_busy(busy_v[1]), .o_count(cnt1));
   ldpc_stream_encoder #(.W(1), .CNT_W(16)) u_w1 (
      .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_valid(i_valid), .o_ready(rdy_v[2]),
      .info_bits(info_bits), .o_valid(vld_v[2]), .i_ready(i_ready), .codeword(cw_v[2]),
      .o_busy(busy_v[2]), .o_count(cnt2));

   assign cnt_v[0] = cnt0;
   assign cnt_v[1] = {14'd0, cnt1};
   assign cnt_v[2] = cnt2;

   // Whole-word reference: parity is the XOR of the matrix rows of all set info bits.
   function automatic logic [10:0] ref_cw(input logic [5:0] info);
      logic [4:0] par;
      par = '0;
      for (int i = 0; i < 6; i++) if (info[i]) par = par ^ P[i*5 +: 5];
      return {info, par};
   endfunction

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, g, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out t=%0t", name, $time);
   endtask

   task automatic run_monitor();
      forever begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
               exp_q[g].delete();
               busy_m[g] = 1'b0;
               wait_m[g] = 1'b0;
               cnt_m[g]  = '0;
            end else begin
               chk("busy", g, busy_v[g], busy_m[g]);
               chk("ready", g, rdy_v[g], !busy_m[g] && i_en);
               chk("count", g, cnt_v[g], cnt_m[g]);
               if (wait_m[g]) begin
                  if (vld_v[g]) begin
                     rise_cyc[g] = cyc;
                     wait_m[g] = 1'b0;
                     chk("latency_enabled_edges", g, en_edges[g], cc[g]);
                  end else if (i_en) begin
                     en_edges[g]++;
                  end
               end else begin
                  chk("valid", g, vld_v[g], busy_m[g]);
               end
               if (vld_v[g]) begin
                  if (exp_q[g].size() == 0) begin
                     timeout("unexpected_codeword");
                  end else begin
                     chk("codeword", g, cw_v[g], exp_q[g][0]);
                     if (i_ready && i_en) begin
                        last_cw[g] = exp_q[g].pop_front();
                        if (g == 0) hist0.push_back(cw_v[0]);
                        cnt_m[g]  = (cnt_m[g] + 16'd1) & cmask[g];
                        busy_m[g] = 1'b0;
                     end
                  end
               end
               if (rdy_v[g] && i_valid) begin
                  exp_q[g].push_back(ref_cw(info_bits));
                  busy_m[g]   = 1'b1;
                  wait_m[g]   = 1'b1;
                  en_edges[g] = 0;
                  acc_cyc[g]  = cyc + 1;
                  acc_cnt[g]++;
                  if (b2b && prev_acc[g] >= 0)
                     chk("b2b_spacing", g, acc_cyc[g] - prev_acc[g], cc[g] + 2);
                  prev_acc[g] = acc_cyc[g];
               end
            end
         end
      end
   endtask

   task automatic chk_reset();
      for (int g = 0; g < 3; g++) begin
         chk("rst_valid", g, vld_v[g], 0);
         chk("rst_busy", g, busy_v[g], 0);
         chk("rst_codeword", g, cw_v[g], 0);
         chk("rst_count", g, cnt_v[g], 0);
         chk("rst_ready", g, rdy_v[g], i_en);
      end
   endtask

   task automatic send_word(input logic [5:0] w);
      int p[3];
      int n;
      n = 0;
      for (int g = 0; g < 3; g++) p[g] = acc_cnt[g];
      info_bits = w;
      i_valid   = 1'b1;
      while (!(acc_cnt[0] > p[0] && acc_cnt[1] > p[1] && acc_cnt[2] > p[2]) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      i_valid = 1'b0;
      if (n >= 50) timeout("send_word");
   endtask

   task automatic wait_acc0();
      int p;
      int n;
      p = acc_cnt[0];
      n = 0;
      while (acc_cnt[0] == p && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) timeout("wait_accept");
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_v[0] || busy_v[1] || busy_v[2]) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) timeout("wait_idle");
   endtask

   initial begin
      int c0;
      int n;
      rst_n = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_ready = 1'b1; info_bits = '0;
      for (int g = 0; g < 3; g++) begin
         acc_cnt[g] = 0; prev_acc[g] = -1; busy_m[g] = 0; wait_m[g] = 0; cnt_m[g] = '0;
      end
      fork
         run_monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_word(6'b000001); wait_idle();
      for (int g = 0; g < 3; g++) begin
         chk("cw_000001", g, last_cw[g], 11'b000001_11000);
         chk("latency", g, rise_cyc[g] - acc_cyc[g], cc[g]);
      end
      chk("count_first", 0, cnt_v[0], 1);
      send_word(6'b100001); wait_idle();
      for (int g = 0; g < 3; g++) chk("cw_100001", g, last_cw[g], 11'b100001_00111);

      // Back-to-back with i_valid held high.
      for (int g = 0; g < 3; g++) prev_acc[g] = -1;
      b2b = 1'b1;
      info_bits = 6'b111111; i_valid = 1'b1;
      wait_acc0();
      info_bits = 6'b000000;
      wait_acc0();
      i_valid = 1'b0;
      wait_idle();
      b2b = 1'b0;
      chk("hist_size", 0, hist0.size(), 4);
      if (hist0.size() >= 4) begin
         chk("cw_111111", 0, hist0[2], 11'b111111_11111);
         chk("cw_000000", 0, hist0[3], 11'd0);
      end
      chk("count_b2b", 0, cnt_v[0], 4);

      // Backpressure in HOLD.
      i_ready = 1'b0;
      send_word(6'($urandom));
      n = 0;
      while (!vld_v[0] && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) timeout("bp_valid_rise");
      c0 = cnt_v[0];
      repeat (10) begin
         @(posedge clk); #1;
         info_bits = 6'($urandom);
         i_valid   = 1'($urandom);
         chk("bp_ready", 0, rdy_v[0], 0);
         chk("bp_valid", 0, vld_v[0], 1);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_handoff_valid", 0, vld_v[0], 0);
      chk("bp_handoff_count", 0, cnt_v[0], c0 + 1);
      wait_idle();

      // Enable dropped for 4 cycles mid-compute.
      send_word(6'($urandom));
      @(posedge clk); #1;
      i_en = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("stall_ready", 0, rdy_v[0], 0);
      end
      i_en = 1'b1;
      wait_idle();
      for (int g = 0; g < 3; g++) chk("stall_latency", g, rise_cyc[g] - acc_cyc[g], cc[g] + 4);

      // Asynchronous reset mid-compute.
      send_word(6'($urandom));
      #2 rst_n = 1'b0;
      #1 chk_reset();
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_word(6'b100001); wait_idle();
      for (int g = 0; g < 3; g++) chk("cw_after_reset", g, last_cw[g], 11'b100001_00111);
      chk("count_after_reset", 0, cnt_v[0], 1);
      repeat (3) begin
         send_word(6'($urandom)); wait_idle();
      end
      chk("count_wrap_w4", 1, cnt_v[1], 0);
      chk("count_four", 0, cnt_v[0], 4);

      // Randomised handshakes and enable.
      repeat (400) begin
         @(posedge clk); #1;
         i_valid   = 1'($urandom_range(0, 1));
         info_bits = 6'($urandom);
         i_ready   = ($urandom_range(0, 3) != 0);
         i_en      = ($urandom_range(0, 7) != 0);
      end
      i_valid = 1'b0; i_ready = 1'b1; i_en = 1'b1;
      @(posedge clk); #1;
      wait_idle();
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) chk("queue_empty", g, exp_q[g].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ldpc_stream_encoder.md
Name: ldpc_stream_encoder

Overview:
Parametrised systematic LDPC encoder, successor to the fixed combinational `top` encoder. It accepts a K-bit info word over a valid/ready handshake and computes the N-K parity bits serially, W info bits per cycle, against a parameter-supplied parity matrix. It holds the N-bit codeword until the downstream stage takes it. It sits between the info-word source and the channel/modulator interface.

Parameters:
N, 11, codeword length.
K, 6, info length; M = N-K parity bits (localparam), must be >= 1.
W, 2, info bits consumed per compute cycle; 1 <= W <= K; K need not be a multiple of W.
P_MATRIX, 30'h3F119998, K*M bits; row i = P_MATRIX[i*M +: M] is the parity contribution of info bit i.
CNT_W, 16, width of the encoded-frame counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
i_en  input  1  global enable; low stalls every state transition and register update except reset.
i_valid  input  1  info word present.
o_ready  output  1  encoder can accept an info word.
info_bits  input  K  info word, sampled on accept.
o_valid  output  1  codeword valid.
i_ready  input  1  downstream accepts the codeword.
codeword  output  N  {info[K-1:0], parity[M-1:0]}; info in MSBs.
o_busy  output  1  state != IDLE.
o_count  output  CNT_W  number of codewords delivered; wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, CALC, HOLD. Localparam C = ceil(K/W) compute cycles. Slice counter width = clog2(C), minimum 1.
- Reset (async assert, sync release): state=IDLE, o_ready=1, o_valid=0, codeword=0, o_busy=0, o_count=0, parity accumulator=0, slice counter=0.
- o_ready = (state==IDLE) && i_en. Accept = i_valid && o_ready on a rising edge.
- On accept:
  - latch info_bits into the info register;
  - clear the accumulator;
  - set slice=0;
  - go to CALC.
- CALC, each enabled cycle:
  - acc ^= XOR over j in [0,W) of (info[slice*W+j] ? row(slice*W+j) : 0);
  - indices >= K in the last slice contribute 0;
  - slice++.
- When slice == C-1, the last update completes and the state goes to HOLD. The codeword register is loaded with {info, final acc} on the same edge.
- Latency: accept at edge t means o_valid=1 after edge t+C when i_en stays high. Default is C=3.
- HOLD: o_valid=1 and codeword stable until o_valid && i_ready && i_en. On that edge:
  - state goes to IDLE;
  - o_valid goes to 0;
  - o_count is incremented.
- No overlap: a new word is not accepted in the handoff cycle. The earliest next accept is the edge after the return to IDLE, which gives a throughput of 1 word per C+2 cycles.
- i_en low: state, slice, acc, o_count and codeword all hold. o_valid keeps its value. o_ready is forced to 0. A handshake is not completed while i_en is low, even if i_ready=1.
- i_valid and the internal info register are ignored outside IDLE. info_bits changing after accept has no effect.
- codeword keeps its last value in IDLE/CALC. It is only meaningful when o_valid=1.
- Reset asserted mid-CALC or mid-HOLD: immediate return to reset values. The pending word is lost and o_count is not incremented.
- o_count wraps from 2^CNT_W-1 to 0.
- Parity is GF(2) only: bitwise AND/XOR, no carries.

Decomposition:
- Shared package ldpc_pkg:
  - default N, K and P_MATRIX;
  - state encoding localparams (IDLE=2'd0, CALC=2'd1, HOLD=2'd2);
  - clog2/ceil-div constant functions.
- Sub-module ldpc_parity_slice: combinational. Takes W info bits, the corresponding W rows and a valid-lane mask. Outputs the M-bit XOR contribution. It is instantiated once, and the top selects the slice.

Test Plan:
- Reset, then info=6'b000001 accepted (i_ready=1). Required: o_valid rises 3 cycles after accept, codeword=11'b000001_11000, and o_count goes to 1 on the handoff edge.
- info=6'b100001 -> codeword=11'b100001_00111. info=6'b111111 -> 11'b111111_11111. info=0 -> 0. Run back-to-back with i_valid held high; required: accepts spaced exactly C+2=5 cycles and o_count=4 at the end.
- Backpressure: i_ready=0 for 10 cycles in HOLD. Required: o_valid and codeword stable, o_ready=0, info_bits changes ignored. Raise i_ready and the handoff occurs on the next edge.
- i_en dropped for 4 cycles mid-CALC. Required: latency extends by exactly 4, the result is unchanged, and o_ready=0 throughout.
- rst_n pulsed low asynchronously mid-CALC. Required: outputs return to reset values immediately, o_count=0, and the next encode is correct.
- Re-parametrise with W=4 (C=2, remainder lanes masked) and W=1 (C=6). Required: the same codewords as the first two scenarios, with latencies 2 and 6. Also check o_count wrap with CNT_W=2 after 4 frames -> 0.
